// File: rtl/jt51_slot_pkg.sv
// jt51_slot_pkg: shared ring geometry and reader FSM state encoding.
//   SLOTS/SW  default ring size and slot index width
//   ST_*      reader states IDLE -> WAIT -> HOLD
package jt51_slot_pkg;
    localparam int SLOTS = 32;
    localparam int SW    = $clog2(SLOTS);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
endpackage

// File: rtl/jt51_slot_cnt.sv
// jt51_slot_cnt: tracks which ring slot the stream carries.
//   rst, clk  async active-high reset, clock
//   cen       one slot advances per enabled cycle
//   zero      ring marker, forces the current slot to 0
//   cur_slot  slot carried by the stream this cycle
//   synced    a zero marker has been seen since reset
module jt51_slot_cnt
    import jt51_slot_pkg::*;
#(
    parameter int slots = SLOTS,
    parameter int sw    = $clog2(slots)
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          zero,
    output logic [sw-1:0] cur_slot,
    output logic          synced
);
    logic [sw-1:0] slot_cnt;

    // a marker at an unexpected slot simply wins over the prediction
    assign cur_slot = zero ? '0 : slot_cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            slot_cnt <= '0;
            synced   <= 1'b0;
        end else if (cen) begin
            slot_cnt <= cur_slot + 1'b1;
            synced   <= synced | zero;
        end
endmodule

// File: rtl/jt51_slot_reader.sv
// jt51_slot_reader: captures one chosen slot of the ring stream for the host.
//   rst, clk, cen   async active-high reset, clock, slot enable
//   zero, din       ring marker and current slot value from the delay line
//   req, req_slot   host request and slot to read; req_ready when idle
//   rd_valid, rd_data, rd_ack   captured value handshake
//   JT51_SLOT_READER_WRITE_EN adds wr_en, wr_data (latched with req) and dout,
//   which replaces din with wr_data during the capture cycle of a write request.
module jt51_slot_reader
    import jt51_slot_pkg::*;
#(
    parameter int width = 10,
    parameter int slots = SLOTS,
    parameter int sw    = $clog2(slots)
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             cen,
    input  logic             zero,
    input  logic [width-1:0] din,
    input  logic             req,
    input  logic [sw-1:0]    req_slot,
    output logic             req_ready,
    output logic             rd_valid,
    output logic [width-1:0] rd_data,
`ifdef JT51_SLOT_READER_WRITE_EN
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] dout,
`endif
    input  logic             rd_ack
);
    logic [1:0]    state;
    logic [sw-1:0] target;
    logic [sw-1:0] cur_slot;
    logic          synced;
    logic          cap;

    jt51_slot_cnt #(.slots(slots), .sw(sw)) u_cnt (
        .rst     (rst),
        .clk     (clk),
        .cen     (cen),
        .zero    (zero),
        .cur_slot(cur_slot),
        .synced  (synced)
    );

    // WAIT is only entered after acceptance, so the acceptance cycle never captures
    assign cap       = state == ST_WAIT && cen && (synced || zero) && cur_slot == target;
    assign req_ready = state == ST_IDLE;
    assign rd_valid  = state == ST_HOLD;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= ST_IDLE;
            target  <= '0;
            rd_data <= '0;
        end else begin
            if (state == ST_IDLE && req) begin
                state  <= ST_WAIT;
                target <= req_slot;
            end
            if (cap) begin
                state   <= ST_HOLD;
                rd_data <= din;
            end
            if (state == ST_HOLD && rd_ack)
                state <= ST_IDLE;
        end

`ifdef JT51_SLOT_READER_WRITE_EN
    logic             wr_q;
    logic [width-1:0] wr_data_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_q      <= 1'b0;
            wr_data_q <= '0;
        end else if (state == ST_IDLE && req) begin
            wr_q      <= wr_en;
            wr_data_q <= wr_data;
        end

    assign dout = cap && wr_q ? wr_data_q : din;
`endif
endmodule

// File: tb/tb_jt51_slot_reader.sv
// tb_jt51_slot_reader: table-driven and randomized check of jt51_slot_reader.
module tb_jt51_slot_reader;
    logic       clk = 0, rst = 1, cen = 0, zero = 0, req = 0, rd_ack = 0;
    logic [9:0] din = 0;
    logic [4:0] req_slot = 0;
    logic       req_ready, rd_valid;
    logic [9:0] rd_data;
`ifdef JT51_SLOT_READER_WRITE_EN
    logic       wr_en = 0;
    logic [9:0] wr_data = 0, dout;
`endif

    jt51_slot_reader #(.width(10), .slots(32)) dut (
        .rst(rst), .clk(clk), .cen(cen), .zero(zero), .din(din),
        .req(req), .req_slot(req_slot), .req_ready(req_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
`ifdef JT51_SLOT_READER_WRITE_EN
        .wr_en(wr_en), .wr_data(wr_data), .dout(dout),
`endif
        .rd_ack(rd_ack)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [9:0] ring [32];
    int pos = 0, period = 1, phase = 0, cens = 0;
    bit zen = 1, rnd = 0;
    bit m_wait, m_hold, m_seen, m_wr;
    int m_tgt;
    logic [9:0] m_data, m_wrd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_hold = 0; m_seen = 0; m_wr = 0;
        m_tgt = 0; m_data = 0; m_wrd = 0;
    endtask

    // One clock: drive the ring stream, advance the transaction model, compare.
    task automatic tick();
        bit cap;
        cen  = rnd ? 1'($urandom_range(0, 1)) : (phase == 0);
        zero = cen && zen && pos == 0;
        din  = ring[pos];
        #1;
        cap = !rst && m_wait && cen && (m_seen || zero) && pos == m_tgt;
`ifdef JT51_SLOT_READER_WRITE_EN
        chk("dout", dout, (cap && m_wr) ? m_wrd : din);
`endif
        if (rst) model_reset();
        else if (m_hold) begin
            if (rd_ack) m_hold = 0;
        end else if (m_wait) begin
            if (cap) begin m_data = din; m_wait = 0; m_hold = 1; end
        end else if (req) begin
            m_wait = 1; m_tgt = int'(req_slot);
`ifdef JT51_SLOT_READER_WRITE_EN
            m_wr = wr_en; m_wrd = wr_data;
`endif
        end
        if (!rst && zero) m_seen = 1;
        @(posedge clk);
        if (cen) begin pos = (pos + 1) % 32; cens++; end
        phase = (phase + 1) % period;
        #1;
        chk("req_ready", req_ready, !m_wait && !m_hold);
        chk("rd_valid", rd_valid, m_hold);
        chk("rd_data", rd_data, m_data);
    endtask

    task automatic resync();
        zen = 1; period = 1; phase = 0;
        repeat (40) tick();
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!rd_valid && n < bound) begin tick(); n++; end
    endtask

    typedef struct {int tgt; int per; bit wr; logic [9:0] wd; logic [9:0] exp;} vec_t;
    vec_t vt [5];

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int start, exp_lat;
        vt[0] = '{7, 1, 0, 10'h000, 10'd21};
        vt[1] = '{31, 4, 0, 10'h000, 10'd93};
        vt[2] = '{0, 1, 0, 10'h000, 10'd0};
        vt[3] = '{5, 1, 1, 10'h2AA, 10'd15};
        vt[4] = '{19, 2, 0, 10'h000, 10'd57};
        for (int i = 0; i < 32; i++) ring[i] = 10'(i * 3);
        model_reset();
        tick(); tick();
        rst = 0;
        resync();

        for (int i = 0; i < 5; i++) begin
            period = vt[i].per; phase = 0;
            req = 1; req_slot = 5'(vt[i].tgt);
`ifdef JT51_SLOT_READER_WRITE_EN
            wr_en = vt[i].wr; wr_data = vt[i].wd;
`endif
            tick();
            req = 0;
`ifdef JT51_SLOT_READER_WRITE_EN
            wr_en = 0; wr_data = 0;
`endif
            exp_lat = ((vt[i].tgt - pos) & 31) + 1;
            start = cens;
            wait_valid(400);
            chk("vec_valid", rd_valid, 1);
            chk("vec_data", rd_data, vt[i].exp);
            chk("vec_lat", cens - start, exp_lat);
            repeat (3) tick();
            rd_ack = 1; req = 1;
            tick();
            rd_ack = 0; req = 0;
            chk("vec_idle", req_ready, 1);
        end

        period = 1; phase = 0;
        while (pos != 12) tick();
        req = 1; req_slot = 12;
        tick();
        req = 0;
        start = cens;
        wait_valid(100);
        chk("rev_lat", cens - start, 32);
        chk("rev_data", rd_data, 36);
        rd_ack = 1; tick(); rd_ack = 0;

        zen = 0; rst = 1;
        tick(); tick();
        rst = 0;
        req = 1; req_slot = 0;
        tick();
        req = 0;
        repeat (100) tick();
        chk("unsync_valid", rd_valid, 0);
        zen = 1;
        wait_valid(64);
        chk("sync_valid", rd_valid, 1);
        chk("sync_data", rd_data, 0);
        rd_ack = 1; tick(); rd_ack = 0;

        resync();
        req = 1; req_slot = 5'((pos + 16) % 32);
        tick();
        req = 0;
        tick();
        rst = 1; #1;
        chk("rstwait_valid", rd_valid, 0);
        chk("rstwait_ready", req_ready, 1);
        tick();
        rst = 0;

        resync();
        req = 1; req_slot = 9;
        tick();
        req = 0;
        wait_valid(64);
        chk("hold_data", rd_data, 27);
        rst = 1; #1;
        chk("rsthold_valid", rd_valid, 0);
        chk("rsthold_ready", req_ready, 1);
        chk("rsthold_data", rd_data, 0);
        tick();
        rst = 0;

        resync();
        for (int i = 0; i < 32; i++) ring[i] = 10'($urandom);
        rnd = 1;
        repeat (800) begin
            req = ($urandom % 3) == 0;
            req_slot = 5'($urandom);
            rd_ack = ($urandom % 4) == 0;
`ifdef JT51_SLOT_READER_WRITE_EN
            wr_en = 1'($urandom);
            wr_data = 10'($urandom);
`endif
            if ($urandom % 200 == 0) pos = 0;
            tick();
        end
        rnd = 0; req = 0; rd_ack = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
